quad_encoder_reader: RTL and testbench

- Reads the A/B quadrature encoder on the motor shaft driven by the PWM H-bridge controller, giving the closed-loop feedback path.
- Synchronises and glitch-filters both channels, then decodes x4 quadrature into a signed position count.
- Measures speed as edge count per fixed time window, with direction.
- Flags illegal transitions (both channels changing in one filtered step).

---
 rtl/quad_encoder_reader_pkg.sv | 58 +++++
 rtl/quad_encoder_reader_if.sv | 32 +++
 rtl/quad_encoder_reader_filter.sv | 75 +++++++
 rtl/quad_encoder_reader.sv | 140 ++++++++++++++
 tb/tb_quad_encoder_reader.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/quad_encoder_reader_pkg.sv
//==============================================================================
// Module      : quad_encoder_reader_pkg
// Description : Shared quadrature encodings, step type and the step lookup
//               used by the encoder reader.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package quad_encoder_reader_pkg;

  localparam int c_AB_W = 2;

  // {A,B} channel states in forward rotation order 00 -> 01 -> 11 -> 10
  typedef enum logic [1:0] {
    Q00 = 2'b00,
    Q01 = 2'b01,
    Q11 = 2'b11,
    Q10 = 2'b10
  } quad_state_t;

  typedef enum logic [1:0] {
    STEP_NONE    = 2'd0,
    STEP_INC     = 2'd1,
    STEP_DEC     = 2'd2,
    STEP_ILLEGAL = 2'd3
  } step_t;

  // Successor of a state in the forward direction
  function automatic logic [1:0] quad_fwd(input logic [1:0] cur);
    logic [1:0] nxt;
    nxt = Q01;
    case (cur)
      Q00:     nxt = Q01;
      Q01:     nxt = Q11;
      Q11:     nxt = Q10;
      default: nxt = Q00;
    endcase
    return nxt;
  endfunction

  // Classify a transition between two filtered {A,B} values
  function automatic step_t quad_step(input logic [1:0] prev, input logic [1:0] cur);
    step_t s;
    s = STEP_NONE;
    if (prev == cur)
      s = STEP_NONE;
    else if ((prev ^ cur) == 2'b11)
      s = STEP_ILLEGAL;
    else if (cur == quad_fwd(prev))
      s = STEP_INC;
    else
      s = STEP_DEC;
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/quad_encoder_reader_if.sv
//==============================================================================
// Module      : quad_encoder_reader_if
// Description : Encoder pins, control and feedback outputs of the reader.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface quad_encoder_reader_if #(
  parameter int POS_W = 16,
  parameter int SPD_W = 16
);
  logic                    enc_a;
  logic                    enc_b;
  logic                    clear_pos;
  logic signed [POS_W-1:0] position;
  logic [SPD_W-1:0]        speed;
  logic                    dir;
  logic                    speed_valid;
  logic                    enc_err;

  modport master (
    output enc_a, enc_b, clear_pos,
    input  position, speed, dir, speed_valid, enc_err
  );

  modport slave (
    input  enc_a, enc_b, clear_pos,
    output position, speed, dir, speed_valid, enc_err
  );
endinterface

`default_nettype wire

// File: rtl/quad_encoder_reader_filter.sv
//==============================================================================
// Module      : enc_input_filter
// Description : Two-flop synchroniser plus run-length glitch filter on a
//               multi-bit bus; all bits are accepted together.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module enc_input_filter #(
  parameter int FILTER_LEN = 4,
  parameter int W          = 2
) (
  input  wire logic         clk,
  input  wire logic         reset_in,
  input  wire logic [W-1:0] i_raw,
  output logic      [W-1:0] o_value,
  output logic              o_accept
);

  localparam int c_CNT_W = $clog2(FILTER_LEN + 1);

  logic [W-1:0]       r_sync1;
  logic [W-1:0]       r_sync2;
  logic [W-1:0]       r_cand;
  logic [W-1:0]       r_value;
  logic               r_have;
  logic               r_accept;
  logic [c_CNT_W-1:0] r_cnt;

  logic               w_differs;
  logic [c_CNT_W-1:0] w_cnt_next;

  // A run continues only while the same candidate is seen on consecutive cycles;
  // before the first acceptance every value counts as new so the resting state loads.
  always_comb begin
    w_differs  = !r_have || (r_sync2 != r_value);
    w_cnt_next = c_CNT_W'(1);
    if ((r_sync2 == r_cand) && (r_cnt != '0))
      w_cnt_next = r_cnt + c_CNT_W'(1);
  end

  // Synchroniser, run counter and accepted value
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_cand   <= '0;
      r_value  <= '0;
      r_have   <= 1'b0;
      r_accept <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1  <= i_raw;
      r_sync2  <= r_sync1;
      r_accept <= 1'b0;
      if (!w_differs) begin
        r_cnt <= '0;
      end else if (w_cnt_next == c_CNT_W'(FILTER_LEN)) begin
        r_value  <= r_sync2;
        r_have   <= 1'b1;
        r_accept <= 1'b1;
        r_cnt    <= '0;
      end else begin
        r_cand <= r_sync2;
        r_cnt  <= w_cnt_next;
      end
    end
  end

  assign o_value  = r_value;
  assign o_accept = r_accept;

endmodule

`default_nettype wire

// File: rtl/quad_encoder_reader.sv
//==============================================================================
// Module      : quad_encoder_reader
// Description : x4 quadrature decoder with signed position, windowed speed
//               and direction, and sticky illegal-transition flag.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module quad_encoder_reader
  import quad_encoder_reader_pkg::*;
#(
  parameter int WINDOW_CYCLES = 1_000_000,
  parameter int FILTER_LEN    = 4,
  parameter int POS_W         = 16,
  parameter int SPD_W         = 16
) (
  input wire logic             clk,
  input wire logic             reset_in,
  quad_encoder_reader_if.slave bus
);

  localparam int c_WIN_W = $clog2(WINDOW_CYCLES);
  // Net count never exceeds one step per cycle, plus a sign bit
  localparam int c_NET_W = $clog2(WINDOW_CYCLES + 1) + 1;
  localparam int c_SAT_W = (c_NET_W > SPD_W) ? c_NET_W : SPD_W;
  localparam logic [c_SAT_W-1:0] c_SPD_MAX = c_SAT_W'({SPD_W{1'b1}});

  logic [c_AB_W-1:0]       w_filt_value;
  logic                    w_filt_accept;
  step_t                   w_step;
  logic signed [POS_W-1:0] w_pos_delta;
  logic signed [c_NET_W-1:0] w_net_delta;
  logic signed [c_NET_W-1:0] w_net_next;
  logic [c_NET_W-1:0]      w_net_mag;
  logic [c_SAT_W-1:0]      w_mag_ext;
  logic [SPD_W-1:0]        w_speed_sat;
  logic                    w_terminal;

  logic                    r_init;
  logic [c_AB_W-1:0]       r_prev_ab;
  logic signed [POS_W-1:0] r_position;
  logic                    r_enc_err;
  logic [c_WIN_W-1:0]      r_win_cnt;
  logic signed [c_NET_W-1:0] r_net;
  logic [SPD_W-1:0]        r_speed;
  logic                    r_dir;
  logic                    r_speed_valid;

  enc_input_filter #(
    .FILTER_LEN (FILTER_LEN),
    .W          (c_AB_W)
  ) u_filter (
    .clk      (clk),
    .reset_in (reset_in),
    .i_raw    ({bus.enc_a, bus.enc_b}),
    .o_value  (w_filt_value),
    .o_accept (w_filt_accept)
  );

  // Classify each accepted change; the first acceptance only seeds the decoder
  always_comb begin
    w_step      = STEP_NONE;
    w_pos_delta = '0;
    w_net_delta = '0;
    if (w_filt_accept && r_init)
      w_step = quad_step(r_prev_ab, w_filt_value);
    if (w_step == STEP_INC) begin
      w_pos_delta = POS_W'(1);
      w_net_delta = c_NET_W'(1);
    end else if (w_step == STEP_DEC) begin
      w_pos_delta = '1;
      w_net_delta = '1;
    end
  end

  // Closing-window magnitude, saturated to the speed width
  always_comb begin
    w_terminal  = (r_win_cnt == c_WIN_W'(WINDOW_CYCLES - 1));
    w_net_next  = r_net + w_net_delta;
    w_net_mag   = w_net_next[c_NET_W-1] ? $unsigned(-w_net_next) : $unsigned(w_net_next);
    w_mag_ext   = c_SAT_W'(w_net_mag);
    w_speed_sat = (w_mag_ext > c_SPD_MAX) ? SPD_W'(c_SPD_MAX) : SPD_W'(w_mag_ext);
  end

  // Decode state, wrapping position and sticky error; clear wins over a step
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      r_init     <= 1'b0;
      r_prev_ab  <= '0;
      r_position <= '0;
      r_enc_err  <= 1'b0;
    end else begin
      if (w_filt_accept) begin
        r_prev_ab <= w_filt_value;
        r_init    <= 1'b1;
      end
      if (bus.clear_pos)
        r_position <= '0;
      else
        r_position <= r_position + w_pos_delta;
      if (w_step == STEP_ILLEGAL)
        r_enc_err <= 1'b1;
      else if (bus.clear_pos)
        r_enc_err <= 1'b0;
    end
  end

  // Speed window: a step in the terminal cycle belongs to the closing window
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      r_win_cnt     <= '0;
      r_net         <= '0;
      r_speed       <= '0;
      r_dir         <= 1'b0;
      r_speed_valid <= 1'b0;
    end else if (w_terminal) begin
      r_win_cnt     <= '0;
      r_net         <= '0;
      r_speed       <= w_speed_sat;
      r_speed_valid <= 1'b1;
      if (w_net_next[c_NET_W-1])
        r_dir <= 1'b0;
      else if (w_net_next != '0)
        r_dir <= 1'b1;
    end else begin
      r_win_cnt     <= r_win_cnt + c_WIN_W'(1);
      r_net         <= w_net_next;
      r_speed_valid <= 1'b0;
    end
  end

  assign bus.position    = r_position;
  assign bus.speed       = r_speed;
  assign bus.dir         = r_dir;
  assign bus.speed_valid = r_speed_valid;
  assign bus.enc_err     = r_enc_err;

endmodule

`default_nettype wire

// File: tb/tb_quad_encoder_reader.sv
//==============================================================================
// Module      : tb_quad_encoder_reader
// Description : Scoreboard bench for the quadrature encoder reader, plus a
//               narrow instance for position wrap and speed saturation.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_quad_encoder_reader;

  localparam int c_WIN = 1000;
  localparam int c_LAT = 7;

  typedef struct { logic signed [15:0] val; int cyc; } pos_exp_t;
  typedef struct { int cyc; int d; } win_step_t;

  logic clk;
  logic reset_in;
  int   cyc;
  int   n_checks;
  int   n_bad;

  pos_exp_t  pos_q[$];
  win_step_t wsteps[$];
  logic signed [15:0] m_pos;
  logic signed [15:0] last_pos;
  logic               m_dir;
  logic [1:0]         ab;
  logic [1:0]         sab;

  quad_encoder_reader_if #(.POS_W(16), .SPD_W(16)) bus ();
  quad_encoder_reader_if #(.POS_W(4),  .SPD_W(3))  sbus ();

  quad_encoder_reader #(
    .WINDOW_CYCLES (c_WIN),
    .FILTER_LEN    (4),
    .POS_W         (16),
    .SPD_W         (16)
  ) dut (
    .clk      (clk),
    .reset_in (reset_in),
    .bus      (bus)
  );

  quad_encoder_reader #(
    .WINDOW_CYCLES (100),
    .FILTER_LEN    (2),
    .POS_W         (4),
    .SPD_W         (3)
  ) dut_small (
    .clk      (clk),
    .reset_in (reset_in),
    .bus      (sbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle stamp: number of rising edges since reset release
  always @(posedge clk) begin
    if (reset_in) cyc <= cyc + 1;
  end

  task automatic check(input string tag, input longint got, input longint want);
    n_checks++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic logic [1:0] nxt_fwd(input logic [1:0] v);
    case (v)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] nxt_rev(input logic [1:0] v);
    case (v)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  // Position scoreboard: every change must match the next expected value and cycle
  always @(negedge clk) begin
    if (reset_in && (bus.position != last_pos)) begin
      if (pos_q.size() == 0) begin
        check("pos_unexpected", bus.position, last_pos);
      end else begin
        pos_exp_t e;
        e = pos_q.pop_front();
        check("pos", bus.position, e.val);
        check("pos_latency", cyc, e.cyc);
      end
      last_pos = bus.position;
    end
  end

  // Speed scoreboard: net of expected steps landing in (c-WIN, c]
  always @(negedge clk) begin
    if (reset_in && bus.speed_valid) begin
      int net;
      int mag;
      net = 0;
      while ((wsteps.size() > 0) && (wsteps[0].cyc <= cyc)) begin
        if (wsteps[0].cyc > cyc - c_WIN) net += wsteps[0].d;
        void'(wsteps.pop_front());
      end
      mag = (net < 0) ? -net : net;
      if (mag > 65535) mag = 65535;
      if (net > 0) m_dir = 1'b1;
      else if (net < 0) m_dir = 1'b0;
      check("win_phase", cyc % c_WIN, 0);
      check("speed", bus.speed, mag);
      check("dir", bus.dir, m_dir);
    end
  end

  task automatic drive_ab(input logic [1:0] v);
    ab = v;
    bus.enc_a = v[1];
    bus.enc_b = v[0];
  endtask

  task automatic clear_pulse();
    bus.clear_pos = 1'b1;
    if (m_pos != 16'sd0) pos_q.push_back('{val: 16'sd0, cyc: cyc + 1});
    m_pos = 16'sd0;
    @(negedge clk);
    bus.clear_pos = 1'b0;
  endtask

  task automatic step(input int d, input int hold);
    drive_ab((d > 0) ? nxt_fwd(ab) : nxt_rev(ab));
    if (d > 0) m_pos = m_pos + 16'sd1;
    else       m_pos = m_pos - 16'sd1;
    pos_q.push_back('{val: m_pos, cyc: cyc + c_LAT});
    wsteps.push_back('{cyc: cyc + c_LAT, d: d});
    repeat (hold) @(negedge clk);
  endtask

  // Legal step whose decode lands on the same edge as a clear
  task automatic step_clear(input int d);
    drive_ab((d > 0) ? nxt_fwd(ab) : nxt_rev(ab));
    wsteps.push_back('{cyc: cyc + c_LAT, d: d});
    repeat (c_LAT - 1) @(negedge clk);
    clear_pulse();
    repeat (4) @(negedge clk);
  endtask

  task automatic jump(input bit with_clear);
    drive_ab(ab ^ 2'b11);
    if (with_clear) begin
      repeat (c_LAT - 1) @(negedge clk);
      clear_pulse();
      repeat (4) @(negedge clk);
    end else begin
      repeat (10) @(negedge clk);
    end
  endtask

  task automatic sstep();
    sab = nxt_fwd(sab);
    sbus.enc_a = sab[1];
    sbus.enc_b = sab[0];
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    cyc = 0; n_checks = 0; n_bad = 0;
    m_pos = 16'sd0; last_pos = 16'sd0; m_dir = 1'b0;
    reset_in = 1'b0;
    bus.clear_pos = 1'b0;
    drive_ab(2'b11);
    sab = 2'b00; sbus.enc_a = 1'b0; sbus.enc_b = 1'b0; sbus.clear_pos = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_position", bus.position, 0);
    check("rst_err", bus.enc_err, 0);
    check("rst_valid", bus.speed_valid, 0);
    reset_in = 1'b1;

    // Resting at 11 only seeds the decoder
    repeat (20) @(negedge clk);
    check("init_position", bus.position, 0);
    check("init_err", bus.enc_err, 0);
    check("init_speed", bus.speed, 0);
    check("init_dir", bus.dir, 0);

    // 11 -> 10 -> 00, clear, then a full forward cycle from 00
    step(1, 10);
    step(1, 10);
    clear_pulse();
    repeat (5) @(negedge clk);
    for (int i = 0; i < 4; i++) step(1, 10);
    check("fwd_position", bus.position, 4);

    // Short glitches on A must be rejected
    bus.enc_a = ~ab[1]; @(negedge clk); bus.enc_a = ab[1];
    repeat (10) @(negedge clk);
    bus.enc_a = ~ab[1]; repeat (3) @(negedge clk); bus.enc_a = ab[1];
    repeat (10) @(negedge clk);
    check("glitch_position", bus.position, 4);
    check("glitch_err", bus.enc_err, 0);

    // Illegal 00 -> 11 jump
    jump(1'b0);
    check("illegal_err", bus.enc_err, 1);
    check("illegal_position", bus.position, 4);
    clear_pulse();
    repeat (3) @(negedge clk);
    check("clear_err", bus.enc_err, 0);
    check("clear_position", bus.position, 0);

    // Window-aligned forward, reverse and idle windows
    for (int i = 0; i < c_WIN && (cyc % c_WIN) != 1; i++) @(negedge clk);
    for (int i = 0; i < 50; i++) step(1, 20);
    for (int i = 0; i < 50; i++) step(-1, 20);
    repeat (c_WIN + 20) @(negedge clk);
    check("idle_dir_held", bus.dir, 0);

    // Clear on the same edge as a legal step, then as an illegal step
    step(1, 10);
    step_clear(1);
    check("clrstep_position", bus.position, 0);
    step(1, 10);
    check("after_clrstep_position", bus.position, 1);
    jump(1'b1);
    check("clr_illegal_err", bus.enc_err, 1);
    check("clr_illegal_position", bus.position, 0);
    clear_pulse();
    repeat (3) @(negedge clk);
    check("final_err", bus.enc_err, 0);
    repeat (20) @(negedge clk);
    check("pos_queue_empty", pos_q.size(), 0);

    // Narrow instance: 4-bit position wraps, 3-bit speed saturates
    check("small_idle_speed", sbus.speed, 0);
    for (int i = 0; i < 7; i++) sstep();
    check("small_pos_max", sbus.position, 7);
    sstep();
    check("small_pos_wrap", sbus.position, -8);
    for (int i = 0; i < 42; i++) sstep();
    check("small_speed_sat", sbus.speed, 7);
    check("small_dir", sbus.dir, 1);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
